// File: rtl/bus_sync_rx.sv
// bus_sync_rx: receiving end of a two-phase toggle req/ack bus crossing.
// Optional parity check on the incoming word via `define BUS_SYNC_RX_PARITY_EN.
module bus_sync_rx #(
    parameter int sword       = 32,
    parameter int sync_stages = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_tgl,
    input  logic [sword-1:0] data_in,
`ifdef BUS_SYNC_RX_PARITY_EN
    input  logic             par_in,
    output logic             par_err,
`endif
    output logic             ack_tgl,
    output logic [sword-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [sync_stages-1:0] sync_q;
    logic                   req_s;
    logic                   pending;

    // Request toggle synchronizer chain; only the last stage feeds logic.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], req_tgl};
        end
    end

    assign req_s   = sync_q[sync_stages-1];
    assign pending = (req_s != ack_tgl);
    assign busy    = (state != IDLE);

`ifdef BUS_SYNC_RX_PARITY_EN
    // Capture/hold/acknowledge FSM; bad-parity words are acked and dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ack_tgl  <= 1'b0;
            valid    <= 1'b0;
            data_out <= '0;
            par_err  <= 1'b0;
        end else begin
            par_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        if (^{data_in, par_in}) begin
                            par_err <= 1'b1;
                            ack_tgl <= ~ack_tgl;
                        end else begin
                            data_out <= data_in;
                            valid    <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid   <= 1'b0;
                        ack_tgl <= ~ack_tgl;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
`else
    // Capture/hold/acknowledge FSM; every pending request is captured.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ack_tgl  <= 1'b0;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        data_out <= data_in;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid   <= 1'b0;
                        ack_tgl <= ~ack_tgl;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bus_sync_rx.sv
// tb_bus_sync_rx: directed bench for bus_sync_rx (sword=32, sync_stages=2).
// Parity steps are built only when BUS_SYNC_RX_PARITY_EN is defined.
module tb_bus_sync_rx;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_tgl = 1'b0;
    logic [31:0] data_in = '0;
    logic        ack_tgl;
    logic [31:0] data_out;
    logic        valid;
    logic        ready = 1'b0;
    logic        busy;
`ifdef BUS_SYNC_RX_PARITY_EN
    logic        par_in = 1'b0;
    logic        par_err;
`endif

    int errors = 0;
    int checks = 0;

    bus_sync_rx #(.sword(32), .sync_stages(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_tgl  (req_tgl),
        .data_in  (data_in),
`ifdef BUS_SYNC_RX_PARITY_EN
        .par_in   (par_in),
        .par_err  (par_err),
`endif
        .ack_tgl  (ack_tgl),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] received[$];
    logic        pre_v;
    logic        pre_r;
    logic [31:0] pre_d;
    logic        prev_ack;
    logic        done;
    int          toggles;

    initial begin
        // Reset asserted mid-cycle, before any clock edge.
        #2 RST = 1'b1;
        #1;
        chk1("rst_ack", ack_tgl, 1'b0);
        chk1("rst_valid", valid, 1'b0);
        chk32("rst_data", data_out, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        step();
        step();
        RST = 1'b0;
        repeat (4) step();
        chk1("idle_valid", valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // Single transfer with ready high.
        data_in = 32'hDEADBEEF;
        req_tgl = 1'b1;
        ready   = 1'b1;
        step();
        chk1("st_e1_valid", valid, 1'b0);
        step();
        chk1("st_e2_valid", valid, 1'b0);
        step();
        chk1("st_e3_valid", valid, 1'b1);
        chk32("st_e3_data", data_out, 32'hDEADBEEF);
        chk1("st_e3_busy", busy, 1'b1);
        chk1("st_e3_ack", ack_tgl, 1'b0);
        step();
        chk1("st_e4_ack", ack_tgl, 1'b1);
        chk1("st_e4_valid", valid, 1'b0);
        chk1("st_e4_busy", busy, 1'b0);
        repeat (5) step();
        chk1("st_norecap", valid, 1'b0);

        // Back-pressure: hold the word while ready is low.
        ready   = 1'b0;
        data_in = 32'hDEADBEEF;
        req_tgl = 1'b0;
        repeat (3) step();
        chk1("bp_valid", valid, 1'b1);
        data_in = 32'h12345678;
        repeat (20) step();
        chk1("bp_hold_valid", valid, 1'b1);
        chk32("bp_hold_data", data_out, 32'hDEADBEEF);
        chk1("bp_hold_ack", ack_tgl, 1'b1);
        ready = 1'b1;
        step();
        chk1("bp_rel_ack", ack_tgl, 1'b0);
        chk1("bp_rel_valid", valid, 1'b0);

        // Stream of 8 words, sender reacting to ack, random ready.
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = 32'h1 << i;
            req_tgl = ~req_tgl;
            done    = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                ready    = 1'($urandom_range(0, 1));
                pre_v    = valid;
                pre_r    = ready;
                pre_d    = data_out;
                prev_ack = ack_tgl;
                step();
                if (pre_v && pre_r) received.push_back(pre_d);
                if (ack_tgl != prev_ack) begin
                    toggles++;
                    done = 1'b1;
                end
            end
            if (!done) chk1("stream_timeout", 1'b0, 1'b1);
        end
        ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pre_v    = valid;
            pre_d    = data_out;
            prev_ack = ack_tgl;
            step();
            if (pre_v) received.push_back(pre_d);
            if (ack_tgl != prev_ack) toggles++;
        end
        chk32("stream_count", 32'(received.size()), 32'd8);
        chk32("stream_toggles", 32'(toggles), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < received.size())
                chk32($sformatf("stream_w%0d", i), received[i], 32'h1 << i);
            else
                chk32($sformatf("stream_w%0d", i), 32'hFFFFFFFF, 32'h1 << i);
        end

        // Reset while holding a word.
        ready   = 1'b0;
        data_in = 32'hA5A5A5A5;
        req_tgl = ~req_tgl;
        repeat (3) step();
        chk1("rh_valid", valid, 1'b1);
        chk32("rh_data", data_out, 32'hA5A5A5A5);
        #3 RST = 1'b1;
        #1;
        chk1("rh_rst_valid", valid, 1'b0);
        chk1("rh_rst_ack", ack_tgl, 1'b0);
        chk1("rh_rst_busy", busy, 1'b0);
        req_tgl = 1'b0;
        data_in = 32'h0;
        step();
        RST = 1'b0;
        repeat (6) step();
        chk1("rh_nocap_valid", valid, 1'b0);
        chk1("rh_nocap_ack", ack_tgl, 1'b0);

`ifdef BUS_SYNC_RX_PARITY_EN
        // Bad parity: word dropped and acknowledged.
        ready   = 1'b0;
        data_in = 32'h00000001;
        par_in  = 1'b0;
        req_tgl = 1'b1;
        step();
        step();
        chk1("par_e2_err", par_err, 1'b0);
        step();
        chk1("par_bad_err", par_err, 1'b1);
        chk1("par_bad_valid", valid, 1'b0);
        chk1("par_bad_ack", ack_tgl, 1'b1);
        step();
        chk1("par_pulse_end", par_err, 1'b0);
        chk1("par_bad_idle", busy, 1'b0);

        // Good parity: normal capture.
        par_in  = 1'b1;
        req_tgl = 1'b0;
        repeat (3) step();
        chk1("par_good_valid", valid, 1'b1);
        chk32("par_good_data", data_out, 32'h00000001);
        chk1("par_good_err", par_err, 1'b0);
        ready = 1'b1;
        step();
        chk1("par_good_ack", ack_tgl, 1'b0);
        chk1("par_good_drop", valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
